fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the instruction decoder.
//  Owns the architectural PC and issues word reads to instruction memory
//  over a req/ack handshake. It presents each fetched word with its PC to
//  the decoder over a valid/ready handshake. Accepts branch redirects from
//  execute and stops fetching once the decoder flags a HALT instruction.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] forced to 0
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   read request to instruction memory
//  imem_addr    out  32  read address; word aligned, stable while imem_req=1
//  imem_ack     in   1   1-cycle pulse: imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word returned by memory
//  instr_valid  out  1   instr/instr_pc hold a fetched instruction for decode
//  instr        out  32  fetched instruction word (feeds decoder instr)
//  instr_pc     out  32  address instr was fetched from
//  instr_ready  in   1   decoder consumes instr when instr_valid & instr_ready
//  halt         in   1   decoder halt flag for current instr; sampled at handshake
//  br_taken     in   1   1-cycle redirect request from execute
//  br_target    in   32  redirect address; bits [1:0] ignored (treated as 00)
//  halted       out  1   fetch permanently stopped until reset
// BEHAVIOUR
//  Reset (async assert, sync release): state=FETCH, pc=RESET_PC,
//   req_addr=RESET_PC, squash=0, instr=0, instr_pc=0, instr_valid=0,
//   halted=0, imem_req=0. imem_req rises 1st edge after rst_n deasserts.
//  States: FETCH, WAIT, HOLD, HALTED (2-bit encoding).
//  FETCH: imem_req=1, imem_addr=pc; latch req_addr=pc; go WAIT next cycle.
//  WAIT: imem_req=1, imem_addr=req_addr (held stable). Ack never in FETCH cycle.
//   ack & !squash & !br_taken: instr<=rdata, instr_pc<=req_addr,
//    pc<=req_addr+4, state->HOLD.
//   ack & (squash|br_taken): drop data, squash<=0, state->FETCH
//    (pc=br_target if br_taken this cycle, else already-redirected pc).
//   !ack & br_taken: pc<=br_target, squash<=1, stay WAIT (old addr held).
//  HOLD: imem_req=0, instr_valid=1; instr/instr_pc stable until handshake.
//   br_taken: highest priority; drop instr, pc<=br_target, instr_valid<=0,
//    ->FETCH; halt ignored that cycle.
//   instr_ready & halt: instr_valid<=0, halted<=1, ->HALTED.
//   instr_ready & !halt: instr_valid<=0, ->FETCH.
//  HALTED: imem_req=0, instr_valid=0, halted=1; br_taken and imem_ack
//   ignored; exit only via reset.
//  Throughput: 1 instr per 3 cycles + memory wait; no prefetch/buffering.
//  PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
//  Stray imem_ack in FETCH/HOLD/HALTED is ignored.
//  Reset mid-transaction: outstanding request abandoned; fetch restarts at
//   RESET_PC; memory must discard any late ack across reset.
// TESTING
//  1 Reset, RESET_PC=0, ack 2 cycles after req -> imem_addr 0,4,8 in order;
//    instr_pc matches; instr = returned data.
//  2 instr_ready low 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0;
//    ready=1 -> next req at pc+4.
//  3 br_taken, br_target=32'h103, during WAIT at addr 8 -> ack data dropped,
//    instr_valid stays 0, next imem_addr=32'h100.
//  4 br_taken same cycle as instr_ready & halt=1 -> no halt; next addr = target.
//  5 Return 32'h0700_0000 (HALT); decoder halt=1, ready=1 -> halted=1,
//    imem_req stays 0 for 20 cycles, br_taken ignored.
//  6 br_target=32'hFFFF_FFFC -> next fetch addr 0; rst_n low during WAIT ->
//    outputs reset immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: owns the PC, reads imem over req/ack,
//               hands words to decode over valid/ready, honours redirects/HALT.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        halt,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        halted
);

    localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        squash_q, squash_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        imem_req_q, imem_req_d;

    logic [31:0] target;
    logic        unused_target_bits;

    assign target             = {br_target[31:2], 2'b00};
    assign unused_target_bits = ^br_target[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        squash_d      = squash_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;

        case (state_q)
            FETCH: begin
                req_addr_d = pc_q;
                state_d    = WAIT;
                // A redirect here still issues the old address; its data is squashed.
                if (br_taken) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    if (squash_q || br_taken) begin
                        squash_d = 1'b0;
                        if (br_taken) pc_d = target;
                        state_d = FETCH;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = req_addr_q;
                        pc_d          = req_addr_q + 32'd4;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else if (br_taken) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    pc_d          = target;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    // Registered so that the request stays low while reset is held.
    assign imem_req_d = (state_d == FETCH) || (state_d == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= C_RESET_PC;
            req_addr_q    <= C_RESET_PC;
            squash_q      <= 1'b0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            squash_q      <= squash_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = (state_q == FETCH) ? pc_q : req_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halt;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .halt        (halt),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, check its address, ack two cycles later, check HOLD outputs.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
        int waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("req_addr", imem_addr, exp_addr);
        tick();
        tick();
        check("addr_stable", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, data);
        check("hold_pc", instr_pc, exp_addr);
        check("hold_req", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic consume(input logic h);
        instr_ready = 1'b1;
        halt        = h;
        tick();
        instr_ready = 1'b0;
        halt        = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        halt        = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'd0;

        // Reset values
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        rst_n = 1'b1;
        tick();
        check("req_after_rst", {31'd0, imem_req}, 32'd1);

        // Sequential fetches from 0
        fetch_one(32'h0, 32'h1111_0000);
        consume(1'b0);
        fetch_one(32'h4, 32'h2222_0004);

        // Decoder stalls for 5 cycles; a stray ack must be ignored
        for (int i = 0; i < 5; i++) begin
            imem_ack   = (i == 2);
            imem_rdata = 32'hBAD0_BAD0;
            tick();
            check("stall_instr", instr, 32'h2222_0004);
            check("stall_pc", instr_pc, 32'h4);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0;
        consume(1'b0);
        check("next_req", {31'd0, imem_req}, 32'd1);
        check("next_addr", imem_addr, 32'h8);

        // Redirect while waiting on address 8
        tick();
        br_taken  = 1'b1;
        br_target = 32'h0000_0103;
        tick();
        br_taken  = 1'b0;
        check("sq_addr_held", imem_addr, 32'h8);
        check("sq_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_0008;
        tick();
        imem_ack = 1'b0;
        check("sq_valid", {31'd0, instr_valid}, 32'd0);
        check("sq_new_addr", imem_addr, 32'h100);
        fetch_one(32'h100, 32'h4444_0100);

        // Redirect beats a halting handshake
        br_taken    = 1'b1;
        br_target   = 32'h0000_0200;
        instr_ready = 1'b1;
        halt        = 1'b1;
        tick();
        br_taken    = 1'b0;
        instr_ready = 1'b0;
        halt        = 1'b0;
        check("brh_halted", {31'd0, halted}, 32'd0);
        check("brh_valid", {31'd0, instr_valid}, 32'd0);
        check("brh_addr", imem_addr, 32'h200);

        // HALT instruction
        fetch_one(32'h200, 32'h0700_0000);
        consume(1'b1);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            br_taken  = i[0];
            br_target = 32'h0000_0300;
            imem_ack  = (i == 5);
            tick();
            check("halted_req", {31'd0, imem_req}, 32'd0);
            check("halted_stays", {31'd0, halted}, 32'd1);
        end
        br_taken = 1'b0;
        imem_ack = 1'b0;

        // PC wrap and reset mid-transaction
        do_reset();
        check("rst2_halted", {31'd0, halted}, 32'd0);
        fetch_one(32'h0, 32'h5555_0000);
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFC;
        tick();
        br_taken = 1'b0;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h6666_FFFC);
        consume(1'b0);
        check("wrap_addr", imem_addr, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        check("async_req", {31'd0, imem_req}, 32'd0);
        check("async_valid", {31'd0, instr_valid}, 32'd0);
        check("async_pc", instr_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        fetch_one(32'h0, 32'h7777_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
